// File: rtl/pipe_pkg.sv
// Shared definitions for the pipe_stage pipeline register:
// occupancy state encoding, flush-counter width and a saturating increment.
`timescale 1ns/1ps
package pipe_pkg;

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  localparam int FLUSH_CNT_W = 16;

  function automatic logic [FLUSH_CNT_W-1:0] sat_inc(input logic [FLUSH_CNT_W-1:0] val);
    if (val == {FLUSH_CNT_W{1'b1}}) begin
      return val;
    end
    return val + 1'b1;
  endfunction

endpackage

// File: rtl/pipe_entry.sv
// One storage slot of the pipe stage: PC, payload and valid bit.
// clear wins over load and returns the slot to its empty image (PC 0, NOP payload).
`timescale 1ns/1ps
module pipe_entry #(
  parameter int                 DATA_W  = 32,
  parameter int                 PC_W    = 32,
  parameter logic [DATA_W-1:0]  NOP_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clear,
  input  logic [PC_W-1:0]   pc_d,
  input  logic [DATA_W-1:0] data_d,
  output logic              valid,
  output logic [PC_W-1:0]   pc,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      pc    <= '0;
      data  <= NOP_VAL;
    end else if (clear) begin
      valid <= 1'b0;
      pc    <= '0;
      data  <= NOP_VAL;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= pc_d;
      data  <= data_d;
    end
  end

endmodule

// File: rtl/pipe_stage.sv
// Pipeline register stage with optional 2-entry skid buffer, stall, flush,
// drop pulse and saturating flush counter. occupancy_o exposes the FSM state.
`timescale 1ns/1ps
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int                DATA_W  = 32,
  parameter int                PC_W    = 32,
  parameter int                SKID    = 1,
  parameter logic [DATA_W-1:0] NOP_VAL = '0
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic [PC_W-1:0]        PC_i,
  input  logic [DATA_W-1:0]      instruction_i,
  input  logic                   Stall_i,
  input  logic                   Flush_i,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [PC_W-1:0]        PC_o,
  output logic [DATA_W-1:0]      instruction_o,
  output logic [1:0]             occupancy_o,
  output logic                   drop_o,
  output logic [FLUSH_CNT_W-1:0] flush_cnt_o
);

  // Handshake: an entry moves upstream->stage when valid_i && ready_o, and
  // stage->downstream when valid_o && ready_i && !Stall_i && !Flush_i.
  // Both transfers happen on the same rising edge that samples them.

  state_e state_q, state_d;

  logic              rst_seen_q;
  logic              base_ready;
  logic              enq, deq;

  logic              main_load, main_clear, main_from_skid;
  logic              main_valid;
  logic [PC_W-1:0]   main_pc, main_pc_d;
  logic [DATA_W-1:0] main_data, main_data_d;

  logic              skid_load, skid_clear;
  logic              skid_valid;
  logic [PC_W-1:0]   skid_pc;
  logic [DATA_W-1:0] skid_data;

  logic                   drop_q;
  logic [FLUSH_CNT_W-1:0] flush_cnt_q;

  // Holds ready_o low until the first rising edge after reset release.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rst_seen_q <= 1'b0;
    end else begin
      rst_seen_q <= 1'b1;
    end
  end

  assign base_ready = rst_seen_q && !Stall_i && !Flush_i;

  generate
    if (SKID != 0) begin : g_ready_skid
      assign ready_o = base_ready && (state_q != FULL);
    end else begin : g_ready_single
      assign ready_o = base_ready && (!main_valid || ready_i);
    end
  endgenerate

  assign enq = valid_i && ready_o;
  assign deq = valid_o && ready_i && !Stall_i && !Flush_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_clear     = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    if (Flush_i) begin
      state_d    = EMPTY;
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      case (state_q)
        EMPTY: begin
          if (enq) begin
            state_d   = ONE;
            main_load = 1'b1;
          end
        end
        ONE: begin
          // With a single-entry stage enq in ONE implies deq, so FULL is unreachable.
          if (enq && deq) begin
            main_load = 1'b1;
          end else if (enq) begin
            state_d   = FULL;
            skid_load = 1'b1;
          end else if (deq) begin
            state_d    = EMPTY;
            main_clear = 1'b1;
          end
        end
        FULL: begin
          if (deq) begin
            state_d        = ONE;
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clear     = 1'b1;
          end
        end
        default: begin
          state_d    = EMPTY;
          main_clear = 1'b1;
          skid_clear = 1'b1;
        end
      endcase
    end
  end

  assign main_pc_d   = main_from_skid ? skid_pc   : PC_i;
  assign main_data_d = main_from_skid ? skid_data : instruction_i;

  pipe_entry #(
    .DATA_W  (DATA_W),
    .PC_W    (PC_W),
    .NOP_VAL (NOP_VAL)
  ) u_main (
    .clk    (clk_i),
    .rst_n  (rst_n_i),
    .load   (main_load),
    .clear  (main_clear),
    .pc_d   (main_pc_d),
    .data_d (main_data_d),
    .valid  (main_valid),
    .pc     (main_pc),
    .data   (main_data)
  );

  generate
    if (SKID != 0) begin : g_skid
      pipe_entry #(
        .DATA_W  (DATA_W),
        .PC_W    (PC_W),
        .NOP_VAL (NOP_VAL)
      ) u_skid (
        .clk    (clk_i),
        .rst_n  (rst_n_i),
        .load   (skid_load),
        .clear  (skid_clear),
        .pc_d   (PC_i),
        .data_d (instruction_i),
        .valid  (skid_valid),
        .pc     (skid_pc),
        .data   (skid_data)
      );
    end else begin : g_no_skid
      assign skid_valid = 1'b0;
      assign skid_pc    = '0;
      assign skid_data  = NOP_VAL;
    end
  endgenerate

  // drop_o reports a flush that actually threw away held work.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      drop_q      <= 1'b0;
      flush_cnt_q <= '0;
    end else begin
      drop_q <= Flush_i && (main_valid || skid_valid);
      if (Flush_i) begin
        flush_cnt_q <= sat_inc(flush_cnt_q);
      end
    end
  end

  assign valid_o       = main_valid;
  assign PC_o          = main_pc;
  assign instruction_o = main_data;
  assign occupancy_o   = state_q;
  assign drop_o        = drop_q;
  assign flush_cnt_o   = flush_cnt_q;

endmodule

// File: tb/tb_pipe_stage.sv
// Bench for pipe_stage: a skid (SKID=1) and a single-entry (SKID=0) instance
// share one directed stimulus; a queue model checks both every cycle.
`timescale 1ns/1ps
module tb_pipe_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        valid_i = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        ready_i = 1'b0;
  logic [31:0] pc_i = '0;
  logic [31:0] instr_i = '0;

  logic        r1, v1, drop1;
  logic [31:0] pc1, in1;
  logic [1:0]  occ1;
  logic [15:0] cnt1;
  logic        r0, v0, drop0;
  logic [31:0] pc0, in0;
  logic [1:0]  occ0;
  logic [15:0] cnt0;

  int checks = 0;
  int errors = 0;

  // Model: each queue holds {pc, data} in delivery order.
  logic [63:0] exp_q1[$];
  logic [63:0] exp_q0[$];
  bit          m_seen = 1'b0;
  bit          m_drop1 = 1'b0;
  bit          m_drop0 = 1'b0;
  int          m_cnt = 0;
  bit          m_r1, m_r0, m_d1, m_d0;
  logic [31:0] e_pc1, e_in1, e_pc0, e_in0;

  pipe_stage #(.DATA_W(32), .PC_W(32), .SKID(1), .NOP_VAL(NOP)) dut1 (
    .clk_i (clk), .rst_n_i (rst_n), .valid_i (valid_i), .ready_o (r1),
    .PC_i (pc_i), .instruction_i (instr_i), .Stall_i (stall), .Flush_i (flush),
    .valid_o (v1), .ready_i (ready_i), .PC_o (pc1), .instruction_o (in1),
    .occupancy_o (occ1), .drop_o (drop1), .flush_cnt_o (cnt1)
  );

  pipe_stage #(.DATA_W(32), .PC_W(32), .SKID(0), .NOP_VAL(NOP)) dut0 (
    .clk_i (clk), .rst_n_i (rst_n), .valid_i (valid_i), .ready_o (r0),
    .PC_i (pc_i), .instruction_i (instr_i), .Stall_i (stall), .Flush_i (flush),
    .valid_o (v0), .ready_i (ready_i), .PC_o (pc0), .instruction_o (in0),
    .occupancy_o (occ0), .drop_o (drop0), .flush_cnt_o (cnt0)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic bit exp_ready(input int size, input bit skid);
    return m_seen && !stall && !flush && (skid ? (size < 2) : (size == 0 || ready_i));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [31:0] pc, input bit rdy,
                       input bit st, input bit fl);
    valid_i = v;
    pc_i    = pc;
    instr_i = pc ^ 32'hC0DE_0000;
    ready_i = rdy;
    stall   = st;
    flush   = fl;
  endtask

  // ---------------- model ----------------
  always begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      exp_q1.delete();
      exp_q0.delete();
      m_seen  = 1'b0;
      m_drop1 = 1'b0;
      m_drop0 = 1'b0;
      m_cnt   = 0;
    end else begin
      m_r1 = exp_ready(exp_q1.size(), 1'b1);
      m_r0 = exp_ready(exp_q0.size(), 1'b0);
      if (flush) begin
        m_drop1 = exp_q1.size() > 0;
        m_drop0 = exp_q0.size() > 0;
        exp_q1.delete();
        exp_q0.delete();
        if (m_cnt < 65535) m_cnt++;
      end else begin
        m_drop1 = 1'b0;
        m_drop0 = 1'b0;
        if (!stall) begin
          m_d1 = (exp_q1.size() > 0) && ready_i;
          m_d0 = (exp_q0.size() > 0) && ready_i;
          if (m_d1) void'(exp_q1.pop_front());
          if (m_d0) void'(exp_q0.pop_front());
          if (valid_i && m_r1) exp_q1.push_back({pc_i, instr_i});
          if (valid_i && m_r0) exp_q0.push_back({pc_i, instr_i});
        end
      end
      m_seen = 1'b1;
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      e_pc1 = (exp_q1.size() > 0) ? exp_q1[0][63:32] : 32'h0;
      e_in1 = (exp_q1.size() > 0) ? exp_q1[0][31:0]  : NOP;
      e_pc0 = (exp_q0.size() > 0) ? exp_q0[0][63:32] : 32'h0;
      e_in0 = (exp_q0.size() > 0) ? exp_q0[0][31:0]  : NOP;
      check("s1_valid", v1, exp_q1.size() > 0);
      check("s1_pc",    pc1, e_pc1);
      check("s1_instr", in1, e_in1);
      check("s1_occ",   occ1, exp_q1.size());
      check("s1_drop",  drop1, m_drop1);
      check("s1_cnt",   cnt1, m_cnt);
      check("s1_ready", r1, exp_ready(exp_q1.size(), 1'b1));
      check("s0_valid", v0, exp_q0.size() > 0);
      check("s0_pc",    pc0, e_pc0);
      check("s0_instr", in0, e_in0);
      check("s0_occ",   occ0, exp_q0.size());
      check("s0_occ_max", occ0 <= 2'd1, 1'b1);
      check("s0_drop",  drop0, m_drop0);
      check("s0_cnt",   cnt0, m_cnt);
      check("s0_ready", r0, exp_ready(exp_q0.size(), 1'b0));
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    drive(0, 0, 0, 0, 0);
    #1 rst_n = 1'b0;
    #1;
    check("rst_valid", v1, 0);
    check("rst_pc",    pc1, 0);
    check("rst_instr", in1, NOP);
    check("rst_occ",   occ1, 0);
    check("rst_drop",  drop1, 0);
    check("rst_cnt",   cnt1, 0);
    check("rst_ready1", r1, 0);
    check("rst_ready0", r0, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    check("post_rel_ready1", r1, 0);
    check("post_rel_ready0", r0, 0);
    tick();
    check("first_edge_ready1", r1, 1);

    // Stream: one entry per cycle, each visible one cycle later.
    drive(1, 4, 1, 0, 0);  tick();
    check("stream_pc4", pc1, 4);
    check("stream_occ", occ1, 1);
    drive(1, 8, 1, 0, 0);  tick();
    check("stream_pc8", pc1, 8);
    check("stream_pc8_s0", pc0, 8);
    drive(1, 12, 1, 0, 0); tick();
    check("stream_pc12", pc1, 12);
    check("stream_valid", v1, 1);
    drive(0, 0, 1, 0, 0);  tick();
    check("drain_valid", v1, 0);
    check("drain_instr", in1, NOP);

    // Backpressure: skid absorbs two entries, then releases in order.
    drive(1, 4, 0, 0, 0);  tick();
    check("bp_pc_first", pc1, 4);
    drive(1, 8, 0, 0, 0);  tick();
    check("bp_occ_full", occ1, 2);
    check("bp_ready_low", r1, 0);
    check("bp_head", pc1, 4);
    check("bp_s0_head", pc0, 4);
    check("bp_s0_occ", occ0, 1);
    drive(0, 0, 1, 0, 0);  tick();
    check("bp_pc_second", pc1, 8);
    check("bp_occ_one", occ1, 1);
    tick();
    check("bp_empty", occ1, 0);

    // Stall holds a full stage; flush overrides stall.
    drive(1, 24, 0, 0, 0); tick();
    drive(1, 28, 0, 0, 0); tick();
    drive(0, 0, 1, 1, 0);  tick();
    check("stall_occ", occ1, 2);
    check("stall_head", pc1, 24);
    tick();
    check("stall_head2", pc1, 24);
    drive(0, 0, 1, 1, 1);  tick();
    check("flush_valid", v1, 0);
    check("flush_instr", in1, NOP);
    check("flush_drop", drop1, 1);
    check("flush_drop_s0", drop0, 1);
    check("flush_cnt", cnt1, 1);
    drive(0, 0, 1, 0, 0);  tick();
    check("drop_one_cycle", drop1, 0);
    check("flush_cnt_hold", cnt1, 1);

    // Flush while empty with an offered entry: nothing dropped, entry lost.
    drive(1, 16, 1, 0, 1); tick();
    check("fe_valid", v1, 0);
    check("fe_drop", drop1, 0);
    check("fe_cnt", cnt1, 2);
    drive(0, 0, 1, 0, 0);  tick();
    check("fe_no_pc16", v1, 0);

    // Asynchronous reset while full, then normal acceptance.
    drive(1, 32, 0, 0, 0); tick();
    drive(1, 36, 0, 0, 0); tick();
    check("pre_rst_full", occ1, 2);
    drive(0, 0, 1, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", v1, 0);
    check("arst_occ", occ1, 0);
    check("arst_pc", pc1, 0);
    check("arst_instr", in1, NOP);
    check("arst_cnt", cnt1, 0);
    check("arst_ready", r1, 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    check("arst_rel_ready", r1, 0);
    tick();
    check("arst_ready_back", r1, 1);
    drive(1, 20, 1, 0, 0); tick();
    check("arst_pc20", pc1, 20);
    check("arst_in20", in1, 32'hC0DE_0014);
    check("arst_pc20_s0", pc0, 20);
    drive(0, 0, 1, 0, 0);  tick();

    // Single-entry stage with ready_i toggling 1,0,1.
    drive(1, 40, 1, 0, 0); tick();
    check("tog_pc40", pc0, 40);
    drive(1, 44, 0, 0, 0);
    #1;
    check("tog_ready_low", r0, 0);
    tick();
    check("tog_hold40", pc0, 40);
    check("tog_occ", occ0, 1);
    check("tog_s1_occ", occ1, 2);
    drive(1, 48, 1, 0, 0);
    #1;
    check("tog_ready_high", r0, 1);
    tick();
    check("tog_pc48", pc0, 48);
    check("tog_s1_pc44", pc1, 44);
    drive(0, 0, 1, 0, 0);
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage.md
PIPE_STAGE -- requirements
Module: pipe_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32: payload (instruction) width in bits.
REQ-002 SHALL have parameter PC_W, default 32: PC field width in bits.
REQ-003 SHALL have parameter SKID, default 1: 0 gives a single-entry register; 1 gives a 2-entry skid buffer.
REQ-004 SHALL have parameter NOP_VAL, default all-zero, DATA_W wide: payload value driven while empty or after flush.
REQ-005 SHALL have port clk_i, input, 1: the single clock, rising-edge.
REQ-006 SHALL have port rst_n_i, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port valid_i, input, 1: upstream entry valid.
REQ-008 SHALL have port ready_o, output, 1: stage accepts an entry this cycle.
REQ-009 SHALL have port PC_i, input, PC_W: upstream PC.
REQ-010 SHALL have port instruction_i, input, DATA_W: upstream payload.
REQ-011 SHALL have port Stall_i, input, 1: freezes the stage (no enqueue, no dequeue).
REQ-012 SHALL have port Flush_i, input, 1: discards all held entries.
REQ-013 SHALL have port valid_o, output, 1: head entry valid.
REQ-014 SHALL have port ready_i, input, 1: downstream accepts the head entry.
REQ-015 SHALL have port PC_o, output, PC_W: head PC.
REQ-016 SHALL have port instruction_o, output, DATA_W: head payload.
REQ-017 SHALL have port occupancy_o, output, 2: number of held entries (0..2).
REQ-018 SHALL have port drop_o, output, 1: registered one-cycle pulse, set when a flush discarded at least one valid entry.
REQ-019 SHALL have port flush_cnt_o, output, 16: count of flush cycles, saturating at 16'hFFFF.

Function
REQ-020 SHALL enqueue when valid_i && ready_o, and dequeue when valid_o && ready_i && !Stall_i && !Flush_i.
REQ-021 SHALL have a latency of one cycle: an entry accepted on edge N appears on valid_o/PC_o/instruction_o after edge N.
REQ-022 SHALL (SKID=1) implement states EMPTY, ONE and FULL; valid_o=1 in ONE and FULL; outputs come from the main register.
REQ-023 SHALL (SKID=1) transition EMPTY: enq->ONE; ONE: enq&deq->ONE with main<=input; ONE: enq&!deq->FULL with skid<=input; ONE: deq&!enq->EMPTY; FULL: deq->ONE with main<=skid.
REQ-024 SHALL (SKID=1) drive ready_o = !Stall_i && !Flush_i && state!=FULL; ready_o SHALL NOT depend on ready_i.
REQ-025 SHALL (SKID=0) drive ready_o = !Stall_i && !Flush_i && (!valid_o || ready_i), allowing back-to-back enqueue and dequeue in one cycle.
REQ-026 SHALL hold all state and outputs unchanged while Stall_i=1 and Flush_i=0.
REQ-027 SHALL give Flush_i priority over Stall_i, valid_i and ready_i: on the next edge go to EMPTY with PC_o=0 and instruction_o=NOP_VAL; any entry offered in the same cycle is dropped.
REQ-028 SHALL drive PC_o=0 and instruction_o=NOP_VAL whenever the stage is EMPTY.
REQ-029 SHALL increment flush_cnt_o on every cycle with Flush_i=1, and hold it at 16'hFFFF without wrapping.
REQ-030 SHALL keep occupancy_o equal to the state encoding (EMPTY=0, ONE=1, FULL=2); with SKID=0 it SHALL never exceed 1.

Reset
REQ-031 SHALL, while rst_n_i=0, asynchronously force EMPTY, valid_o=0, PC_o=0, instruction_o=NOP_VAL, occupancy_o=0, drop_o=0 and flush_cnt_o=0.
REQ-032 SHALL discard in-flight entries on reset mid-operation, and SHALL drive ready_o=0 during reset and until the first rising edge after deassertion.

Structure
REQ-033 SHALL place the state encoding (EMPTY/ONE/FULL) and the flush-counter width constant in the shared package pipe_pkg.
REQ-034 SHALL implement the storage for one entry (PC plus payload plus valid) as sub-module pipe_entry, instantiated once for SKID=0 and twice for SKID=1.

Verification
REQ-035 SHALL cover stream with SKID=1: valid_i=1 every cycle, ready_i=1, PCs 4, 8, 12 -> same PCs on PC_o one cycle later, occupancy_o=1, no bubbles.
REQ-036 SHALL cover backpressure: ready_i=0 for 2 cycles while PCs 4 and 8 are offered -> occupancy_o=2, ready_o=0; on ready_i=1, PC_o shows 4 then 8, with no loss or duplication.
REQ-037 SHALL cover Stall_i=1 with Flush_i=1 while FULL -> next cycle valid_o=0, instruction_o=NOP_VAL, drop_o=1 for exactly one cycle, flush_cnt_o incremented by 1.
REQ-038 SHALL cover flush with valid_i=1 and PC_i=16 while EMPTY -> PC 16 never appears, drop_o=0.
REQ-039 SHALL cover rst_n_i dropped mid-cycle while FULL -> outputs clear immediately (no clock edge); after release the stage accepts PC 20 normally.
REQ-040 SHALL cover SKID=0 with ready_i toggling 1,0,1 -> occupancy_o never exceeds 1, and ready_o follows REQ-025 each cycle.
